queue: RTL and testbench
========================

Name: queue

Overview:
- Synchronous FIFO: the first-in-first-out counterpart of the team's LIFO stack block.
- Same PUSH/POP/FULL/EMPTY handshake as the stack, so the two are drop-in alternatives behind the top-level pin wrapper.
- Reads return entries in arrival order, not reverse order.
- Adds an occupancy count, a synchronous flush, and sticky error flags for misuse.

Parameters:
- WIDTH, 1, data bits per entry.
- DEPTH, 8, number of entries; any integer >= 2, power of two not required.
- CW, $clog2(DEPTH+1), width of COUNT. Derived; not overridden by users.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- CLEAR  input  1  synchronous flush; highest priority after reset.
- PUSH  input  1  write request, DATA_IN sampled on the same edge.
- POP  input  1  read request; removes the entry currently on DATA_OUT.
- DATA_IN  input  WIDTH  write data.
- DATA_OUT  output  WIDTH  oldest entry (first-word-fall-through), registered.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- COUNT  output  CW  current occupancy, 0..DEPTH.
- OVERFLOW  output  1  sticky: push attempted while full.
- UNDERFLOW  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (RST_N low, asynchronous):
  - write pointer, read pointer and COUNT = 0.
  - EMPTY = 1, FULL = 0, DATA_OUT = 0, OVERFLOW = 0, UNDERFLOW = 0.
  - Storage contents are don't-care.
- Deassertion is sampled normally: the first push can occur on the first edge with RST_N high.
- CLEAR = 1 at an edge:
  - Same result as reset on pointers, COUNT, flags and DATA_OUT.
  - PUSH and POP on that edge are ignored and raise no error flags.
- Accepted push: PUSH=1 and (!FULL or POP=1).
  - Writes DATA_IN at the write pointer, then advances the pointer.
- Accepted pop: POP=1 and !EMPTY.
  - Advances the read pointer.
- Pointers wrap from DEPTH-1 to 0.
- COUNT:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- FULL and EMPTY are decoded from registered COUNT, so they are valid the cycle after the causing edge.
- Simultaneous PUSH and POP:
  - Neither full nor empty: both accepted, COUNT unchanged.
  - Full: both accepted, COUNT stays DEPTH, no OVERFLOW.
  - Empty: push accepted, pop rejected, UNDERFLOW set, COUNT becomes 1.
- PUSH while full without POP: data dropped, storage and pointers unchanged, OVERFLOW set.
- POP while empty: no state change, UNDERFLOW set, DATA_OUT unchanged.
- OVERFLOW and UNDERFLOW stay set until reset or CLEAR.
- DATA_OUT is registered, always the entry at the read pointer after the edge. Cases:
  - Push into empty: DATA_OUT = pushed word after that edge, so latency is 1 cycle.
  - Pop with COUNT >= 2: DATA_OUT = next-oldest word after the edge.
  - Pop leaving the queue empty: DATA_OUT holds its last value; consumers qualify it with !EMPTY.
  - Push+pop with COUNT == 1: DATA_OUT = the pushed word.
- No combinational path from PUSH, POP or DATA_IN to any output.

Test Plan:
- Reset and fill, WIDTH=4 DEPTH=4:
  - Stimulus: reset, then push 0x1,0x2,0x3,0x4 on consecutive edges.
  - Required: COUNT goes 1..4; EMPTY drops after the first edge; FULL=1 after the fourth; DATA_OUT=0x1 from the first edge onward.
- Order check:
  - Stimulus: from the full state, pop four times.
  - Required: DATA_OUT goes 0x2,0x3,0x4 after successive pops; EMPTY=1 and COUNT=0 after the fourth pop; DATA_OUT stays 0x4.
- Wrap-around:
  - Stimulus: 10 cycles of alternating push and pop with values 0x5..0xE.
  - Required: every popped value equals the value pushed one cycle earlier; COUNT toggles 1/0; no flags set.
- Boundary simultaneity:
  - Stimulus: full with 0xA..0xD, push 0xE with pop on one edge.
  - Required: COUNT=4, FULL=1, OVERFLOW=0, DATA_OUT=0xB; a later drain yields 0xB,0xC,0xD,0xE.
  - Stimulus: empty, push 0x7 with pop.
  - Required: COUNT=1, DATA_OUT=0x7, UNDERFLOW=1.
- Misuse and clear:
  - Stimulus: push 0x9 while full without pop.
  - Required: OVERFLOW=1, contents unchanged.
  - Stimulus: pop while empty.
  - Required: UNDERFLOW=1.
  - Stimulus: CLEAR with PUSH=1.
  - Required: COUNT=0, EMPTY=1, both flags 0, no write.
- Asynchronous reset mid-operation:
  - Stimulus: COUNT=3, drop RST_N between clock edges.
  - Required: all outputs reach reset values immediately, without waiting for an edge; after release, push 0x3 gives COUNT=1, DATA_OUT=0x3.

Source files
------------

// File: rtl/queue.sv
// Synchronous FIFO with first-word-fall-through registered output, occupancy count,
// synchronous flush and sticky overflow/underflow flags.
module queue #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLEAR,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             FULL,
  output logic             EMPTY,
  output logic [CW-1:0]    COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full, empty;
  logic             push_acc, pop_acc;
  logic [PW-1:0]    wr_ptr_inc, rd_ptr_inc;

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == '0);
    push_acc   = PUSH && (!full || POP) && !CLEAR;
    pop_acc    = POP && !empty && !CLEAR;
    wr_ptr_inc = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_inc = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (CLEAR) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      data_out_d  = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_inc;
      if (pop_acc)  rd_ptr_d = rd_ptr_inc;

      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      // The head after the edge is the incoming word only when it lands in an
      // otherwise-empty queue; otherwise it is the next stored entry, or unchanged.
      if (push_acc && (empty || (pop_acc && count_q == CW'(1)))) begin
        data_out_d = DATA_IN;
      end else if (pop_acc && count_q > CW'(1)) begin
        data_out_d = mem_q[rd_ptr_inc];
      end

      if (PUSH && full && !POP) overflow_d  = 1'b1;
      if (POP && empty)         underflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_acc) mem_q[wr_ptr_q] <= DATA_IN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign DATA_OUT  = data_out_q;
  assign FULL      = full;
  assign EMPTY     = empty;
  assign COUNT     = count_q;
  assign OVERFLOW  = overflow_q;
  assign UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_queue.sv
// Directed-vector bench for the queue FIFO at WIDTH=4, DEPTH=4; expected values
// are hand-computed constants.
module tb_queue;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  int checks   = 0;
  int failures = 0;

  queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CLEAR    (clear),
    .PUSH     (push),
    .POP      (pop),
    .DATA_IN  (data_in),
    .DATA_OUT (data_out),
    .FULL     (full),
    .EMPTY    (empty),
    .COUNT    (count),
    .OVERFLOW (overflow),
    .UNDERFLOW(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Checks occupancy, status and head word together.
  task automatic check_state(input string tag, input int exp_count, input logic exp_empty,
                             input logic exp_full, input logic [WIDTH-1:0] exp_dout);
    check({tag, ".count"}, 32'(count), 32'(exp_count));
    check({tag, ".empty"}, 32'(empty), 32'(exp_empty));
    check({tag, ".full"},  32'(full),  32'(exp_full));
    check({tag, ".dout"},  32'(data_out), 32'(exp_dout));
  endtask

  task automatic check_flags(input string tag, input logic exp_ovf, input logic exp_unf);
    check({tag, ".ovf"}, 32'(overflow),  32'(exp_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(exp_unf));
  endtask

  // One clock of stimulus; outputs are stable for sampling on return.
  task automatic cycle(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
    @(negedge clk);
    push = p; pop = q; data_in = d; clear = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    $display("txn push=%0b pop=%0b clr=%0b din=%0h -> count=%0d dout=%0h e=%0b f=%0b ovf=%0b unf=%0b",
             p, q, c, d, count, data_out, empty, full, overflow, underflow);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 1'b1, 1'b0, 4'h0);
    check_flags("reset", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b0, 4'(i), 1'b0);
      check_state($sformatf("fill%0d", i), i, 1'b0, (i == 4), 4'h1);
    end

    // Drain in arrival order
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("pop1", 3, 1'b0, 1'b0, 4'h2);
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("pop2", 2, 1'b0, 1'b0, 4'h3);
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("pop3", 1, 1'b0, 1'b0, 4'h4);
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("pop4", 0, 1'b1, 1'b0, 4'h4);

    // Wrap-around: alternating push/pop
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 4'(5 + i), 1'b0);
      check_state($sformatf("wrap_push%0d", i), 1, 1'b0, 1'b0, 4'(5 + i));
      cycle(1'b0, 1'b1, 4'h0, 1'b0);
      check_state($sformatf("wrap_pop%0d", i), 0, 1'b1, 1'b0, 4'(5 + i));
    end
    check_flags("wrap", 1'b0, 1'b0);

    // Full push+pop
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'(10 + i), 1'b0);
    check_state("fullAD", 4, 1'b0, 1'b1, 4'hA);
    cycle(1'b1, 1'b1, 4'hE, 1'b0);
    check_state("full_pp", 4, 1'b0, 1'b1, 4'hB);
    check_flags("full_pp", 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("drain1", 3, 1'b0, 1'b0, 4'hC);
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("drain2", 2, 1'b0, 1'b0, 4'hD);
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("drain3", 1, 1'b0, 1'b0, 4'hE);
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("drain4", 0, 1'b1, 1'b0, 4'hE);

    // Empty push+pop
    cycle(1'b1, 1'b1, 4'h7, 1'b0);
    check_state("empty_pp", 1, 1'b0, 1'b0, 4'h7);
    check_flags("empty_pp", 1'b0, 1'b1);

    // Overflow: fill to 7,1,2,3 then push 9 alone
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, 4'(i), 1'b0);
    cycle(1'b1, 1'b0, 4'h9, 1'b0);
    check_state("ovf", 4, 1'b0, 1'b1, 4'h7);
    check_flags("ovf", 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("ovf_d1", 3, 1'b0, 1'b0, 4'h1);
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("ovf_d2", 2, 1'b0, 1'b0, 4'h2);
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("ovf_d3", 1, 1'b0, 1'b0, 4'h3);
    cycle(1'b0, 1'b1, 4'h0, 1'b0); check_state("ovf_d4", 0, 1'b1, 1'b0, 4'h3);

    // Clear with push pending
    cycle(1'b1, 1'b0, 4'h5, 1'b1);
    check_state("clear", 0, 1'b1, 1'b0, 4'h0);
    check_flags("clear", 1'b0, 1'b0);

    // Underflow from a clean state
    cycle(1'b0, 1'b1, 4'h0, 1'b0);
    check_state("unf", 0, 1'b1, 1'b0, 4'h0);
    check_flags("unf", 1'b0, 1'b1);

    // Clear with push+pop pending
    cycle(1'b1, 1'b1, 4'hF, 1'b1);
    check_state("clear2", 0, 1'b1, 1'b0, 4'h0);
    check_flags("clear2", 1'b0, 1'b0);

    // Async reset at COUNT=3, with a sticky flag set
    cycle(1'b1, 1'b0, 4'h6, 1'b0);
    cycle(1'b1, 1'b0, 4'h7, 1'b0);
    cycle(1'b1, 1'b0, 4'h8, 1'b0);
    cycle(1'b1, 1'b0, 4'h9, 1'b0);
    cycle(1'b0, 1'b1, 4'h0, 1'b0);
    check_state("pre_rst", 3, 1'b0, 1'b0, 4'h7);
    check_flags("pre_rst", 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 0, 1'b1, 1'b0, 4'h0);
    check_flags("async_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 4'h3, 1'b0);
    check_state("post_rst", 1, 1'b0, 1'b0, 4'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
